// File: rtl/mem_sync_fifo_pkg.sv
// Shared helpers for the synchronous FIFO and its storage.
package mem_sync_fifo_pkg;

  // True when n is a non-zero power of two; used by elaboration-time checks.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem_simple_dual_port.sv
// Simple dual-port RAM: one write port (a), one read port (b).
// OUTPUT_DELAY=0 gives a combinational read; larger values add read registers.
module mem_simple_dual_port #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 16,
  parameter int                    OUTPUT_DELAY  = 0,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input  logic                     clka,
  input  logic                     wea,
  input  logic [$clog2(DEPTH)-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dina,
  input  logic                     clkb,
  input  logic                     reb,
  input  logic [$clog2(DEPTH)-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    doutb
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  // Write port: one entry per clka edge when enabled.
  always_ff @(posedge clka) begin
    if (wea) begin
      mem_reg[addra] <= dina;
    end
  end

  if (OUTPUT_DELAY == 0) begin : g_comb_read
    // Asynchronous read; the caller owns any pipelining. Clock and enable
    // of port b have no role here.
    logic unused_port_b;
    assign unused_port_b = reb ^ clkb;
    assign doutb = mem_reg[addrb];
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] stage_reg [OUTPUT_DELAY];

    // Read pipeline, advanced only while reb is high.
    always_ff @(posedge clkb) begin
      if (reb) begin
        stage_reg[0] <= mem_reg[addrb];
        for (int i = 1; i < OUTPUT_DELAY; i++) begin
          stage_reg[i] <= stage_reg[i-1];
        end
      end
    end

    assign doutb = stage_reg[OUTPUT_DELAY-1];
  end

endmodule

// File: rtl/mem_sync_fifo.sv
// Single-clock FIFO on dual-port RAM with occupancy, status flags, flush,
// sticky overflow/underflow and a resettable 1- or 2-stage read pipeline.
module mem_sync_fifo
  import mem_sync_fifo_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 16,
  parameter int                    OUTPUT_DELAY  = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int                    AF_THRESH     = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_data_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (OUTPUT_DELAY != 1 && OUTPUT_DELAY != 2) begin : g_bad_delay
    $error("mem_sync_fifo: OUTPUT_DELAY must be 1 or 2");
  end
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("mem_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_THRESH > DEPTH || AF_THRESH < 0) begin : g_bad_thresh
    $error("mem_sync_fifo: AF_THRESH must lie in 0..DEPTH");
  end

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  empty_reg;
  logic                  full_reg;
  logic                  almost_full_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  active;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  logic [OUTPUT_DELAY-1:0] valid_pipe_reg;
  logic [DATA_WIDTH-1:0]   data_pipe_reg [OUTPUT_DELAY];

  // Reset and flush both suppress any RAM/pointer activity this cycle.
  assign active    = ~reset & ~flush;
  assign rd_accept = active & rd_en & ~empty_reg;
  // A full FIFO still takes a write when a read frees the slot at the same edge.
  assign wr_accept = active & wr_en & (~full_reg | rd_accept);

  mem_simple_dual_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DEPTH        (DEPTH),
    .OUTPUT_DELAY (0),
    .DEFAULT_VALUE(DEFAULT_VALUE)
  ) u_ram (
    .clka (clk),
    .wea  (wr_accept),
    .addra(wr_ptr_reg),
    .dina (wr_data),
    .clkb (clk),
    .reb  (1'b1),
    .addrb(rd_ptr_reg),
    .doutb(ram_rd_data)
  );

  // Occupancy after this edge; drives the registered flags so they track count.
  always_comb begin
    count_next = count_reg;
    if (wr_accept && !rd_accept) begin
      count_next = count_reg + CNT_W'(1);
    end else if (rd_accept && !wr_accept) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      empty_reg       <= 1'b1;
      full_reg        <= 1'b0;
      almost_full_reg <= (AF_THRESH == 0);
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      empty_reg       <= 1'b1;
      full_reg        <= 1'b0;
      almost_full_reg <= (AF_THRESH == 0);
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg       <= count_next;
      empty_reg       <= (count_next == '0);
      full_reg        <= (count_next == CNT_W'(DEPTH));
      almost_full_reg <= (count_next >= CNT_W'(AF_THRESH));
      if (wr_en && !wr_accept) overflow_reg  <= 1'b1;
      if (rd_en && empty_reg)  underflow_reg <= 1'b1;
    end
  end

  // Read pipeline: data only advances alongside a valid, so rd_data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_pipe_reg <= '0;
      for (int i = 0; i < OUTPUT_DELAY; i++) begin
        data_pipe_reg[i] <= DEFAULT_VALUE;
      end
    end else begin
      valid_pipe_reg[0] <= rd_accept;
      if (rd_accept) data_pipe_reg[0] <= ram_rd_data;
      for (int i = 1; i < OUTPUT_DELAY; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1] & ~flush;
        if (valid_pipe_reg[i-1] && !flush) data_pipe_reg[i] <= data_pipe_reg[i-1];
      end
    end
  end

  assign rd_data       = data_pipe_reg[OUTPUT_DELAY-1];
  assign rd_data_valid = valid_pipe_reg[OUTPUT_DELAY-1];
  assign count         = count_reg;
  assign empty         = empty_reg;
  assign full          = full_reg;
  assign almost_full   = almost_full_reg;
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;

endmodule
